// File: rtl/layer1_to_layer2_feeder_pkg.sv
// Shared configuration for the layer-1 to layer-2 feeder: network dimensions,
// accumulator/feature widths, requantisation shift and FSM state encoding.
package layer1_to_layer2_feeder_pkg;

    localparam int DATA_WIDTH        = 16;
    localparam int NUM_WEIGHT_LAYER2 = 128;
    localparam int NUM_NEURON_LAYER1 = 128;
    localparam int ACC_WIDTH         = 48;
    localparam int REQUANT_SHIFT     = 8;
    localparam int ADDR_WIDTH        = 7;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CLEAR  = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } feeder_state_t;

endpackage

// File: rtl/layer1_to_layer2_feeder_relu_requant.sv
// ReLU, truncating right-shift and positive saturation of one signed
// layer-1 accumulator element down to a non-negative signed feature.
module relu_requant
    import layer1_to_layer2_feeder_pkg::*;
#(
    parameter int ACC_W  = ACC_WIDTH,
    parameter int DATA_W = DATA_WIDTH,
    parameter int SHIFT  = REQUANT_SHIFT
) (
    input  logic [ACC_W-1:0]  acc,
    output logic [DATA_W-1:0] feature
);

    localparam logic [DATA_W-1:0] MAX_POS = {1'b0, {(DATA_W-1){1'b1}}};

    logic [ACC_W-1:0] shifted;
    logic             overflow;

    // Only non-negative values reach the shift, so a logical shift is exact;
    // any set bit at or above the feature sign position means saturation.
    always_comb begin
        shifted  = acc >> SHIFT;
        overflow = |shifted[ACC_W-1:DATA_W-1];
        if (acc[ACC_W-1]) begin
            feature = '0;
        end else if (overflow) begin
            feature = MAX_POS;
        end else begin
            feature = shifted[DATA_W-1:0];
        end
    end

endmodule

// File: rtl/layer1_to_layer2_feeder.sv
// Captures the packed layer-1 accumulator vector, requantises each element and
// streams them one per cycle into layer2, sequencing layer2's accumulator clear.
module layer1_to_layer2_feeder
    import layer1_to_layer2_feeder_pkg::*;
#(
    parameter int NUM_IN = NUM_WEIGHT_LAYER2,
    parameter int ACC_W  = ACC_WIDTH,
    parameter int DATA_W = DATA_WIDTH,
    parameter int SHIFT  = REQUANT_SHIFT,
    parameter int ADDR_W = ADDR_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_IN*ACC_W-1:0] in_vec,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [DATA_W-1:0]       feature_out,
    output logic [ADDR_W-1:0]       addr_out,
    output logic                    acc_clear,
    output logic                    busy,
    output logic                    done
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_IN - 1);
    localparam logic [ADDR_W:0]   NUM_IN_EXT = (ADDR_W + 1)'(NUM_IN);

    feeder_state_t           state;
    logic [NUM_IN*ACC_W-1:0] buffer;
    logic [ADDR_W-1:0]       idx;
    logic [ADDR_W-1:0]       selIdx;
    logic [ACC_W-1:0]        selElem;
    logic [DATA_W-1:0]       qElem;
    logic                    capture;

    assign capture = (state == IDLE) && in_valid && in_ready;

    // Element mux; idx runs one past the last element at the end of a stream,
    // so it is folded back to 0 to keep the part-select in range.
    always_comb begin
        selIdx  = ({1'b0, idx} < NUM_IN_EXT) ? idx : '0;
        selElem = buffer[ACC_W*selIdx +: ACC_W];
    end

    relu_requant #(
        .ACC_W  (ACC_W),
        .DATA_W (DATA_W),
        .SHIFT  (SHIFT)
    ) u_relu_requant (
        .acc     (selElem),
        .feature (qElem)
    );

    // Input buffer is loaded only on a capture, so it stays stable mid-stream.
    always_ff @(posedge clk) begin
        if (!rst && capture) begin
            buffer <= in_vec;
        end
    end

    // Sequencer: idle/clear/stream/done with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            idx         <= '0;
            in_ready    <= 1'b1;
            feature_out <= '0;
            addr_out    <= '0;
            acc_clear   <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    in_ready    <= 1'b1;
                    acc_clear   <= 1'b0;
                    feature_out <= '0;
                    addr_out    <= '0;
                    busy        <= 1'b0;
                    done        <= 1'b0;
                    if (capture) begin
                        state     <= CLEAR;
                        idx       <= '0;
                        in_ready  <= 1'b0;
                        acc_clear <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                CLEAR: begin
                    state       <= STREAM;
                    acc_clear   <= 1'b0;
                    feature_out <= qElem;
                    addr_out    <= idx;
                    idx         <= idx + 1'b1;
                end
                STREAM: begin
                    if (addr_out == LAST_ADDR) begin
                        state       <= DONE;
                        feature_out <= '0;
                        addr_out    <= '0;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                    end else begin
                        feature_out <= qElem;
                        addr_out    <= idx;
                        idx         <= idx + 1'b1;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    idx      <= '0;
                    done     <= 1'b0;
                    in_ready <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_layer1_to_layer2_feeder.sv
// Self-checking bench for layer1_to_layer2_feeder with a behavioural layer2
// accumulator model driven by the feeder outputs.
module tb_layer1_to_layer2_feeder;

    localparam int NUM_IN = 4;
    localparam int ACC_W  = 48;
    localparam int DATA_W = 16;
    localparam int SHIFT  = 8;
    localparam int ADDR_W = 2;
    localparam int VEC_W  = NUM_IN * ACC_W;
    localparam int Q_W    = NUM_IN * DATA_W;

    logic             clk = 1'b0;
    logic             rst;
    logic [VEC_W-1:0] in_vec;
    logic             in_valid;
    logic             in_ready;
    logic [DATA_W-1:0] feature_out;
    logic [ADDR_W-1:0] addr_out;
    logic             acc_clear;
    logic             busy;
    logic             done;

    int     checks = 0;
    int     errors = 0;
    longint layer2Acc = 0;

    typedef struct {
        logic [ACC_W-1:0]  x;
        logic [DATA_W-1:0] q;
    } vec_t;

    vec_t vectors [8];

    layer1_to_layer2_feeder #(
        .NUM_IN (NUM_IN),
        .ACC_W  (ACC_W),
        .DATA_W (DATA_W),
        .SHIFT  (SHIFT),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_vec      (in_vec),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .feature_out (feature_out),
        .addr_out    (addr_out),
        .acc_clear   (acc_clear),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    function automatic longint weightOf(input int k);
        return longint'(k * 3 + 1);
    endfunction

    // Behavioural layer2: cleared by acc_clear or rst, otherwise accumulates feature*weight.
    always @(posedge clk) begin
        if (rst || acc_clear) begin
            layer2Acc <= 0;
        end else begin
            layer2Acc <= layer2Acc + longint'($signed(feature_out)) * weightOf(int'(addr_out));
        end
    end

    // Reference requantisation from plain arithmetic.
    function automatic logic [DATA_W-1:0] qRef(input logic [ACC_W-1:0] raw);
        longint x;
        longint y;
        longint maxPos;
        x      = longint'($signed(raw));
        maxPos = (longint'(1) << (DATA_W - 1)) - 1;
        if (x < 0) return '0;
        y = x / (longint'(1) << SHIFT);
        if (y > maxPos) y = maxPos;
        return DATA_W'(y);
    endfunction

    function automatic logic [ACC_W-1:0] randElem();
        logic [63:0] r;
        r = {$urandom, $urandom};
        case ($urandom_range(0, 3))
            0:       return r[ACC_W-1:0] | {1'b1, {(ACC_W-1){1'b0}}};
            1:       return ACC_W'(r[23:0]);
            2:       return ACC_W'(r[24:0]);
            default: return {1'b0, r[ACC_W-2:0]};
        endcase
    endfunction

    function automatic longint expectedSum(input logic [Q_W-1:0] expq);
        longint s;
        s = 0;
        for (int k = 0; k < NUM_IN; k++) begin
            s += longint'(expq[k*DATA_W +: DATA_W]) * weightOf(k);
        end
        return s;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // One full capture/stream run with per-cycle checks and the layer2 result at the end.
    task automatic applyStimulus(input logic [VEC_W-1:0] vec, input logic [Q_W-1:0] expq);
        longint sum;
        sum = expectedSum(expq);
        @(negedge clk);
        in_vec   = vec;
        in_valid = 1'b1;
        checkOutput("ready_before_capture", 64'(in_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_vec   = ~vec;
        checkOutput("clear_acc_clear", 64'(acc_clear), 64'd1);
        checkOutput("clear_busy", 64'(busy), 64'd1);
        checkOutput("clear_in_ready", 64'(in_ready), 64'd0);
        for (int j = 0; j < NUM_IN; j++) begin
            @(negedge clk);
            checkOutput($sformatf("stream_feature[%0d]", j), 64'(feature_out), 64'(expq[j*DATA_W +: DATA_W]));
            checkOutput($sformatf("stream_addr[%0d]", j), 64'(addr_out), 64'(j));
            checkOutput($sformatf("stream_acc_clear[%0d]", j), 64'(acc_clear), 64'd0);
        end
        @(negedge clk);
        checkOutput("done_pulse", 64'(done), 64'd1);
        checkOutput("done_feature", 64'(feature_out), 64'd0);
        checkOutput("done_busy", 64'(busy), 64'd0);
        @(negedge clk);
        checkOutput("after_done", 64'(done), 64'd0);
        checkOutput("after_ready", 64'(in_ready), 64'd1);
        checkOutput("layer2_result", 64'(layer2Acc), 64'(sum));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [VEC_W-1:0] vec;
        logic [VEC_W-1:0] vecB;
        logic [Q_W-1:0]   expq;
        logic [Q_W-1:0]   expqB;
        int               doneCount;
        bit               sawDone;

        vectors[0] = '{48'h0000_0001_2345, 16'h0123};
        vectors[1] = '{48'h0000_0001_2345, 16'h0123};
        vectors[2] = '{48'h0000_0001_2345, 16'h0123};
        vectors[3] = '{48'h0000_0001_2345, 16'h0123};
        vectors[4] = '{-48'sd5,            16'h0000};
        vectors[5] = '{48'h0000_007F_FF00, 16'h7FFF};
        vectors[6] = '{48'h0000_0080_0000, 16'h7FFF};
        vectors[7] = '{48'h7FFF_FFFF_FFFF, 16'h7FFF};

        rst      = 1'b1;
        in_valid = 1'b0;
        in_vec   = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
        checkOutput("reset_acc_clear", 64'(acc_clear), 64'd1);
        checkOutput("reset_feature", 64'(feature_out), 64'd0);
        checkOutput("reset_addr", 64'(addr_out), 64'd0);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_done", 64'(done), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("idle_acc_clear", 64'(acc_clear), 64'd0);

        // Table-driven runs, NUM_IN records per capture.
        for (int g = 0; g < 2; g++) begin
            for (int k = 0; k < NUM_IN; k++) begin
                vec[k*ACC_W +: ACC_W]   = vectors[g*NUM_IN + k].x;
                expq[k*DATA_W +: DATA_W] = vectors[g*NUM_IN + k].q;
            end
            applyStimulus(vec, expq);
        end

        // Idle hold: layer2 result stays put for 10 cycles.
        repeat (10) @(negedge clk);
        checkOutput("idle_hold_result", 64'(layer2Acc), 64'(expectedSum(expq)));
        checkOutput("idle_hold_feature", 64'(feature_out), 64'd0);

        // Randomised back-to-back runs against the reference model.
        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < NUM_IN; k++) begin
                vec[k*ACC_W +: ACC_W]    = randElem();
                expq[k*DATA_W +: DATA_W] = qRef(vec[k*ACC_W +: ACC_W]);
            end
            applyStimulus(vec, expq);
        end

        // in_valid held high: second capture only after done; in_vec changes mid-stream ignored.
        for (int k = 0; k < NUM_IN; k++) begin
            vec[k*ACC_W +: ACC_W]     = 48'h0000_0000_1000 * ACC_W'(k + 1);
            expq[k*DATA_W +: DATA_W]  = qRef(vec[k*ACC_W +: ACC_W]);
            vecB[k*ACC_W +: ACC_W]    = 48'h0000_0000_0300 * ACC_W'(k + 2);
            expqB[k*DATA_W +: DATA_W] = qRef(vecB[k*ACC_W +: ACC_W]);
        end
        @(negedge clk);
        in_vec   = vec;
        in_valid = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= NUM_IN + 2; c++) begin
            @(negedge clk);
            if (c == 3) in_vec = vecB;
        end
        checkOutput("held_done", 64'(done), 64'd1);
        checkOutput("held_ready_in_done", 64'(in_ready), 64'd0);
        @(negedge clk);
        checkOutput("held_ready_after", 64'(in_ready), 64'd1);
        checkOutput("held_no_early_clear", 64'(acc_clear), 64'd0);
        checkOutput("held_first_result", 64'(layer2Acc), 64'(expectedSum(expq)));
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("held_second_clear", 64'(acc_clear), 64'd1);
        sawDone = 1'b0;
        for (int c = 0; c < 20 && !sawDone; c++) begin
            @(negedge clk);
            if (done) sawDone = 1'b1;
        end
        checkOutput("held_second_done_seen", 64'(sawDone), 64'd1);
        @(negedge clk);
        checkOutput("held_second_result", 64'(layer2Acc), 64'(expectedSum(expqB)));

        // Reset in the middle of the stream at index 2.
        @(negedge clk);
        in_vec   = vec;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("pre_reset_addr", 64'(addr_out), 64'd2);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("midrst_acc_clear", 64'(acc_clear), 64'd1);
        checkOutput("midrst_feature", 64'(feature_out), 64'd0);
        checkOutput("midrst_addr", 64'(addr_out), 64'd0);
        checkOutput("midrst_in_ready", 64'(in_ready), 64'd1);
        checkOutput("midrst_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        doneCount = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (done) doneCount++;
        end
        checkOutput("midrst_no_done", 64'(doneCount), 64'd0);
        checkOutput("midrst_layer2_cleared", 64'(layer2Acc), 64'd0);

        // A fresh run after the aborted one still works.
        for (int k = 0; k < NUM_IN; k++) begin
            vec[k*ACC_W +: ACC_W]    = randElem();
            expq[k*DATA_W +: DATA_W] = qRef(vec[k*ACC_W +: ACC_W]);
        end
        applyStimulus(vec, expq);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
